// File: rtl/multi_clk_div_pkg.sv
// Shared definitions for the multi-channel clock divider.
//   NChDefault   : default number of divider channels
//   WidthDefault : default bit width of a division ratio
//   ch_idx_w()   : width of a channel index (never less than 1)
package multi_clk_div_pkg;

  localparam int unsigned NChDefault   = 4;
  localparam int unsigned WidthDefault = 8;

  function automatic int unsigned ch_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/multi_clk_div_ch.sv
// One divider channel: active ratio, shadow ratio with pending flag, phase counter and divided
// clock register. Ratio updates wait for a period boundary, so a period in progress is never cut.
//   clk_i     : reference clock (rising edge)
//   rst_i     : asynchronous active-high reset
//   en_i      : divide enable for this channel
//   wr_i      : accepted ratio write (top only asserts it while pend_o is low)
//   ratio_i   : ratio to place in the shadow register
//   pend_o    : shadow register holds a ratio not yet applied
//   div_clk_o : divided clock, or clk_i itself in bypass
//   tick_o    : high in the first cycle of every divided period
module clk_div_ch
  import multi_clk_div_pkg::*;
#(
  parameter int unsigned WIDTH = WidthDefault
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             wr_i,
  input  logic [WIDTH-1:0] ratio_i,
  output logic             pend_o,
  output logic             div_clk_o,
  output logic             tick_o
);

  localparam logic [WIDTH-1:0] RatioOne = WIDTH'(1);

  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic             en_q, en_d;
  logic             div_q, div_d;

  logic             div_mode;
  logic             div_mode_d;
  logic             wrap;
  logic             boundary;
  logic [WIDTH-1:0] half_d;

  // Mode is decoded from registered state so enable changes land on the next edge.
  assign div_mode = en_q && (r_q > RatioOne);
  assign wrap     = (cnt_q == (r_q - RatioOne));
  assign boundary = !div_mode || wrap;

  always_comb begin
    r_d      = r_q;
    shadow_d = shadow_q;
    pend_d   = pend_q;
    en_d     = en_i;
    cnt_d    = boundary ? '0 : cnt_q + RatioOne;

    if (boundary && pend_q) begin
      r_d    = shadow_q;
      pend_d = 1'b0;
      cnt_d  = '0;
    end

    // A write landing on a boundary only sets pending; it is applied at the next boundary.
    if (wr_i && !pend_q) begin
      shadow_d = ratio_i;
      pend_d   = 1'b1;
    end

    div_mode_d = en_i && (r_d > RatioOne);
    if (!div_mode_d) begin
      cnt_d = '0;
    end

    // ceil(R/2) without widening: R=2^WIDTH-1 gives 2^(WIDTH-1), which still fits.
    half_d = (r_d >> 1) + {{(WIDTH-1){1'b0}}, r_d[0]};
    div_d  = div_mode_d && (cnt_d < half_d);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_q      <= '0;
      shadow_q <= '0;
      cnt_q    <= '0;
      pend_q   <= 1'b0;
      en_q     <= 1'b0;
      div_q    <= 1'b0;
    end else begin
      r_q      <= r_d;
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      en_q     <= en_d;
      div_q    <= div_d;
    end
  end

  // Mode select and div_q both change on the rising edge while clk_i is high, and divide mode
  // always starts with div_q high, so switching between sources cannot produce a runt pulse.
  assign div_clk_o = div_mode ? div_q : clk_i;
  assign tick_o    = div_mode && (cnt_q == '0);
  assign pend_o    = pend_q;

endmodule

// File: rtl/multi_clk_div.sv
// Multi-channel programmable clock divider. Holds the ratio-write decode and the ready mux;
// each channel is an instance of clk_div_ch.
//   clk_ref     : reference clock, all flops on its rising edge
//   rst         : asynchronous active-high reset
//   i_clk_en    : per-channel divide enable
//   i_cfg_vld   : ratio-write request
//   i_cfg_ch    : target channel of the write
//   i_cfg_ratio : new division ratio
//   o_cfg_rdy   : write can be accepted this cycle (always 1 for a non-existent channel)
//   o_div_clk   : divided clocks
//   o_tick      : one-cycle pulse at the start of each divided period
module multi_clk_div
  import multi_clk_div_pkg::*;
#(
  parameter  int unsigned N_CH  = NChDefault,
  parameter  int unsigned WIDTH = WidthDefault,
  localparam int unsigned ChW   = ch_idx_w(N_CH)
) (
  input  logic             clk_ref,
  input  logic             rst,
  input  logic [N_CH-1:0]  i_clk_en,
  input  logic             i_cfg_vld,
  input  logic [ChW-1:0]   i_cfg_ch,
  input  logic [WIDTH-1:0] i_cfg_ratio,
  output logic             o_cfg_rdy,
  output logic [N_CH-1:0]  o_div_clk,
  output logic [N_CH-1:0]  o_tick
);

  logic [N_CH-1:0] pend;
  logic [N_CH-1:0] wr;
  logic [31:0]     cfg_ch_ext;

  assign cfg_ch_ext = 32'(i_cfg_ch);

  // Index codes with no channel behind them match nothing: ready stays 1, the write is dropped.
  always_comb begin
    o_cfg_rdy = 1'b1;
    wr        = '0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      if (cfg_ch_ext == c) begin
        o_cfg_rdy = ~pend[c];
        wr[c]     = i_cfg_vld & ~pend[c];
      end
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    clk_div_ch #(
      .WIDTH(WIDTH)
    ) u_ch (
      .clk_i    (clk_ref),
      .rst_i    (rst),
      .en_i     (i_clk_en[g]),
      .wr_i     (wr[g]),
      .ratio_i  (i_cfg_ratio),
      .pend_o   (pend[g]),
      .div_clk_o(o_div_clk[g]),
      .tick_o   (o_tick[g])
    );
  end

endmodule

// File: doc/multi_clk_div.md
MULTI_CLK_DIV -- requirements
Module: multi_clk_div

Interface
REQ-001 The block SHALL have parameter N_CH, default 4, meaning the number of independent divider channels (1..16).
REQ-002 The block SHALL have parameter WIDTH, default 8, meaning the bit width of each division ratio.
REQ-003 The block SHALL have port clk_ref, input, 1 bit: the single reference clock; all flops are clocked on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port i_clk_en, input, N_CH bits: per-channel divide enable.
REQ-006 The block SHALL have port i_cfg_vld, input, 1 bit: ratio-write request.
REQ-007 The block SHALL have port i_cfg_ch, input, $clog2(N_CH) bits (minimum 1): target channel of the write.
REQ-008 The block SHALL have port i_cfg_ratio, input, WIDTH bits: the new division ratio.
REQ-009 The block SHALL have port o_cfg_rdy, output, 1 bit: the write can be accepted this cycle.
REQ-010 The block SHALL have port o_div_clk, output, N_CH bits: the divided clocks.
REQ-011 The block SHALL have port o_tick, output, N_CH bits: a one-cycle pulse marking the start of each divided period.

Function
REQ-012 Each channel SHALL hold an active ratio R, a shadow ratio and a pending flag.
REQ-013 A channel SHALL be in divide mode when i_clk_en[ch]=1 and R>=2; otherwise it SHALL be in bypass mode.
REQ-014 In bypass mode, o_div_clk[ch] SHALL equal clk_ref (via a glitch-free mux), cnt SHALL be held at 0, and o_tick[ch] SHALL be 0.
REQ-015 In divide mode, counter cnt SHALL run 0..R-1 and wrap to 0; the registered output SHALL be high for ceil(R/2) cycles (cnt < ceil(R/2)) and low for floor(R/2) cycles.
REQ-016 o_tick[ch] SHALL be 1 exactly in cycles where cnt==0 in divide mode.
REQ-017 A period boundary SHALL be a cycle with cnt==R-1 in divide mode, or any cycle in bypass mode.
REQ-018 A write SHALL be accepted when i_cfg_vld=1 and o_cfg_rdy=1: the shadow register gets i_cfg_ratio and pending is set on the next edge.
REQ-019 o_cfg_rdy SHALL equal ~pending[i_cfg_ch] combinationally; for i_cfg_ch>=N_CH it SHALL be 1 and the write SHALL be dropped.
REQ-020 At a boundary with pending=1, R SHALL load the shadow value, pending SHALL clear, and cnt SHALL go to 0.
REQ-021 A write accepted in the same cycle as a boundary SHALL apply at the following boundary, never mid-period.
REQ-022 Deassertion of i_clk_en[ch] SHALL take effect on the next edge: cnt goes to 0 and the channel enters bypass.
REQ-023 On assertion of i_clk_en[ch], the channel SHALL start at cnt=0 with output high and o_tick=1.
REQ-024 Ratio arithmetic SHALL be unsigned WIDTH-bit; R=2^WIDTH-1 SHALL be supported without overflow.

Reset
REQ-025 While rst=1, all cnt values SHALL be 0, all R and shadow registers SHALL be 0 (bypass), pending SHALL be 0, o_tick SHALL be 0, the divide registers SHALL be 0, and o_cfg_rdy SHALL be 1.
REQ-026 Reset asserted mid-period SHALL clear state immediately, and pending writes SHALL be discarded.

Structure
REQ-027 A shared package multi_clk_div_pkg SHALL hold the defaults for N_CH and WIDTH and the channel-index width function.
REQ-028 Per-channel logic SHALL be a sub-module clk_div_ch instantiated N_CH times by generate; the top level SHALL hold only the config decode and the rdy mux.

Verification
REQ-029 Reset then enable channel 0 and write ratio 4 -> the first change applies at the next boundary; o_div_clk[0] is 2 high / 2 low, with o_tick every 4 cycles.
REQ-030 Write ratio 5 to channel 1 with enable set -> 3 high / 2 low; the period measures 50 ns at a 10 ns clk_ref.
REQ-031 Write ratio 8 then ratio 3 mid-period -> the period in progress completes at 8, then runs at 3; a second write is refused (o_cfg_rdy=0) while pending.
REQ-032 Write ratios 0 and 1, and separately deassert enable -> o_div_clk equals clk_ref with o_tick=0.
REQ-033 Write to i_cfg_ch=5 with N_CH=4 -> o_cfg_rdy=1, and no channel changes.
REQ-034 Assert rst mid-period on all channels running ratio 7 -> outputs go to their reset values at once; after release, all channels are in bypass with pending=0.
